// File: rtl/memory_unit.sv
// memory_unit: byte-addressable big-endian memory for the multicycle MIPS
// datapath. Accepts one request per MOV/MOC handshake. It performs the access
// after a fixed wait latency and reports misaligned or out-of-range accesses.
module memory_unit #(
  parameter int ADDR_BITS = 9,
  parameter int LATENCY   = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mov,
  input  logic        rw,
  input  logic [1:0]  mode,
  input  logic        sign_ext,
  input  logic [31:0] address,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        moc,
  output logic        addr_err
);

  localparam int MEM_BYTES = 1 << ADDR_BITS;
  localparam logic [3:0] LAT_M1 = 4'(LATENCY - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_BUSY = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic        rw_q, rw_d;
  logic [1:0]  mode_q, mode_d;
  logic        sext_q, sext_d;
  logic [31:0] data_out_q, data_out_d;
  logic        addr_err_q, addr_err_d;
  logic        do_write;

  logic [7:0] mem [MEM_BYTES];

  // Byte lanes of the latched request, big-endian: lane 0 is the lowest address.
  logic [ADDR_BITS-1:0] idx0, idx1, idx2, idx3;
  logic [7:0]           b0, b1, b2, b3;
  logic                 is_word, is_half, acc_err, ext;
  logic [31:0]          rd_data;

  assign idx0 = addr_q[ADDR_BITS-1:0];
  assign idx1 = idx0 + ADDR_BITS'(1);
  assign idx2 = idx0 + ADDR_BITS'(2);
  assign idx3 = idx0 + ADDR_BITS'(3);
  assign b0   = mem[idx0];
  assign b1   = mem[idx1];
  assign b2   = mem[idx2];
  assign b3   = mem[idx3];

  // Mode 2'b11 is treated as a word access.
  assign is_word = mode_q[1];
  assign is_half = (mode_q == 2'b01);
  assign acc_err = (is_word && (addr_q[1:0] != 2'b00))
                 || (is_half && addr_q[0])
                 || (|addr_q[31:ADDR_BITS]);
  // The top bit of the first byte is the sign bit for both byte and halfword loads.
  assign ext     = sext_q & b0[7];

  // Load data formatting: extend byte/halfword, pass word through.
  always_comb begin
    // NOTE: every comb output gets a default first so no latch is inferred.
    rd_data = 32'd0;
    if (is_word)      rd_data = {b0, b1, b2, b3};
    else if (is_half) rd_data = {{16{ext}}, b0, b1};
    else              rd_data = {{24{ext}}, b0};
  end

  // Handshake FSM and the access-completion logic.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rw_d       = rw_q;
    mode_d     = mode_q;
    sext_d     = sext_q;
    data_out_d = data_out_q;
    addr_err_d = addr_err_q;
    do_write   = 1'b0;
    case (state_q)
      ST_IDLE: if (mov) begin
        addr_d  = address;
        wdata_d = data_in;
        rw_d    = rw;
        mode_d  = mode;
        sext_d  = sign_ext;
        cnt_d   = LAT_M1;
        state_d = ST_BUSY;
      end
      ST_BUSY: if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        addr_err_d = acc_err;
        data_out_d = (acc_err || !rw_q) ? 32'd0 : rd_data;
        do_write   = !acc_err && !rw_q;
        state_d    = ST_DONE;
      end
      ST_DONE: if (!mov) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Control and request registers with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= 4'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
      rw_q       <= 1'b0;
      mode_q     <= 2'b00;
      sext_q     <= 1'b0;
      data_out_q <= 32'd0;
      addr_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rw_q       <= rw_d;
      mode_q     <= mode_d;
      sext_q     <= sext_d;
      data_out_q <= data_out_d;
      addr_err_q <= addr_err_d;
    end
  end

  // Storage array: commits only the addressed bytes; a reset aborts the write.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset so it can map onto RAM.
    if (do_write && !reset) begin
      if (is_word) begin
        mem[idx0] <= wdata_q[31:24];
        mem[idx1] <= wdata_q[23:16];
        mem[idx2] <= wdata_q[15:8];
        mem[idx3] <= wdata_q[7:0];
      end else if (is_half) begin
        mem[idx0] <= wdata_q[15:8];
        mem[idx1] <= wdata_q[7:0];
      end else begin
        mem[idx0] <= wdata_q[7:0];
      end
    end
  end

  assign data_out = data_out_q;
  assign addr_err = addr_err_q;
  assign moc      = (state_q == ST_DONE);

endmodule

// File: tb/tb_memory_unit.sv
// tb_memory_unit: directed handshake sequence against memory_unit.
// Expected results are queued when a request is driven and popped when
// MOC is seen.
module tb_memory_unit;

  localparam int LATENCY = 2;

  logic        clk = 1'b0;
  logic        reset, mov, rw, sign_ext;
  logic [1:0]  mode;
  logic [31:0] address, data_in, data_out;
  logic        moc, addr_err;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
  } exp_t;
  exp_t sb[$];

  memory_unit #(.ADDR_BITS(9), .LATENCY(LATENCY)) dut (
    .clk(clk), .reset(reset), .mov(mov), .rw(rw), .mode(mode),
    .sign_ext(sign_ext), .address(address), .data_in(data_in),
    .data_out(data_out), .moc(moc), .addr_err(addr_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issue one request, wait for MOC, compare against the queued expectation,
  // optionally keep mov high for 'hold' extra edges, then release.
  task automatic do_op(input string tag, input logic r, input logic [1:0] m,
                       input logic se, input logic [31:0] a, input logic [31:0] d,
                       input logic [31:0] exp_d, input logic exp_e, input int hold);
    exp_t got;
    int   lat;
    sb.push_back('{err: exp_e, data: exp_d});
    @(negedge clk);
    mov = 1'b1; rw = r; mode = m; sign_ext = se; address = a; data_in = d;
    lat = 0;
    while (!moc && lat < 40) begin
      @(posedge clk); #1;
      lat++;
      // Request is latched on the first edge; later changes must be ignored.
      if (lat == 1) begin
        address = a ^ 32'h4;
        data_in = ~d;
        sign_ext = ~se;
      end
    end
    check({tag, "_moc"}, 32'(moc), 32'd1);
    check({tag, "_latency"}, 32'(lat - 1), 32'(LATENCY));
    got = sb.pop_front();
    check({tag, "_data"}, data_out, got.data);
    check({tag, "_err"}, 32'(addr_err), 32'(got.err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check({tag, "_hold_moc"}, 32'(moc), 32'd1);
    end
    @(negedge clk);
    mov = 1'b0;
    @(posedge clk); #1;
    check({tag, "_release"}, 32'(moc), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int w;
    reset = 1'b1; mov = 1'b0; rw = 1'b1; mode = 2'b10; sign_ext = 1'b0;
    address = 32'd0; data_in = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_moc", 32'(moc), 32'd0);
    check("rst_err", 32'(addr_err), 32'd0);
    check("rst_data", data_out, 32'd0);
    @(negedge clk); reset = 1'b0;

    // Word write then readback, byte/halfword loads with extension.
    do_op("w_wr10",  1'b0, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 0);
    do_op("w_rd10",  1'b1, 2'b10, 1'b1, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 0);
    do_op("b_rd10s", 1'b1, 2'b00, 1'b1, 32'h10, 32'h0, 32'hFFFFFFDE, 1'b0, 0);
    do_op("b_rd13z", 1'b1, 2'b00, 1'b0, 32'h13, 32'h0, 32'h000000EF, 1'b0, 0);
    do_op("h_rd12s", 1'b1, 2'b01, 1'b1, 32'h12, 32'h0, 32'hFFFFBEEF, 1'b0, 0);
    do_op("h_rd12z", 1'b1, 2'b01, 1'b0, 32'h12, 32'h0, 32'h0000BEEF, 1'b0, 0);

    // Partial writes touch only the addressed bytes.
    do_op("h_wr12",  1'b0, 2'b01, 1'b0, 32'h12, 32'hFFFF1234, 32'h0, 1'b0, 0);
    do_op("b_wr10",  1'b0, 2'b00, 1'b0, 32'h10, 32'hFFFFFF55, 32'h0, 1'b0, 0);
    do_op("w_rd10b", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h55AD1234, 1'b0, 0);
    do_op("m3_rd10", 1'b1, 2'b11, 1'b1, 32'h10, 32'h0, 32'h55AD1234, 1'b0, 0);

    // Error cases: misaligned and out of range; memory untouched.
    do_op("w_wr11",  1'b0, 2'b10, 1'b0, 32'h11, 32'h99999999, 32'h0, 1'b1, 0);
    do_op("h_rd11",  1'b1, 2'b01, 1'b0, 32'h11, 32'h0, 32'h0, 1'b1, 0);
    do_op("w_rd10c", 1'b1, 2'b10, 1'b0, 32'h10, 32'h0, 32'h55AD1234, 1'b0, 0);
    do_op("w_rd200", 1'b1, 2'b10, 1'b0, 32'h200, 32'h0, 32'h0, 1'b1, 0);
    do_op("b_wr1ff", 1'b0, 2'b00, 1'b0, 32'h1FF, 32'h000000A5, 32'h0, 1'b0, 0);
    do_op("b_rd1ff", 1'b1, 2'b00, 1'b1, 32'h1FF, 32'h0, 32'hFFFFFFA5, 1'b0, 0);

    // Reset mid-BUSY aborts the pending write.
    do_op("w_wr20",  1'b0, 2'b10, 1'b0, 32'h20, 32'h00000000, 32'h0, 1'b0, 0);
    @(negedge clk);
    mov = 1'b1; rw = 1'b0; mode = 2'b10; address = 32'h20; data_in = 32'hCAFEF00D;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk); #1;
    check("rstbusy_moc", 32'(moc), 32'd0);
    check("rstbusy_data", data_out, 32'd0);
    check("rstbusy_err", 32'(addr_err), 32'd0);
    @(negedge clk); reset = 1'b0; mov = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rstbusy_idle", 32'(moc), 32'd0);
    do_op("w_rd20",  1'b1, 2'b10, 1'b0, 32'h20, 32'h0, 32'h00000000, 1'b0, 0);

    // Reset while in DONE clears all outputs on that edge.
    @(negedge clk);
    mov = 1'b1; rw = 1'b1; mode = 2'b01; address = 32'h11; sign_ext = 1'b0;
    w = 0;
    while (!moc && w < 40) begin @(posedge clk); #1; w++; end
    check("rstdone_pre_err", 32'(addr_err), 32'd1);
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    check("rstdone_moc", 32'(moc), 32'd0);
    check("rstdone_err", 32'(addr_err), 32'd0);
    check("rstdone_data", data_out, 32'd0);
    @(negedge clk); reset = 1'b0; mov = 1'b0;

    // Holding mov in DONE performs exactly one access.
    do_op("w_wr30h", 1'b0, 2'b10, 1'b0, 32'h30, 32'h11223344, 32'h0, 1'b0, 5);
    do_op("w_rd30",  1'b1, 2'b10, 1'b0, 32'h30, 32'h0, 32'h11223344, 1'b0, 0);

    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/memory_unit.md
# memory_unit

Byte-addressable data/instruction memory for the multicycle MIPS datapath, sitting directly downstream of the control unit and its MAR/MDR registers. It accepts a request (address, write data, size, direction) under a MOV/MOC handshake, performs the access after a fixed wait latency and raises MOC so the control FSM can leave its memory-wait state. It supports byte, halfword and word transfers, big-endian, with optional sign extension on loads and alignment/range error reporting.

## Interface
Parameters:
- ADDR_BITS, 9, memory is 2^ADDR_BITS bytes (512)
- LATENCY, 2, clock edges from MOV acceptance to MOC assertion; legal range 1..15

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  synchronous, active-high; one clock, reset is synchronous and active-high
- mov  input  1  memory operation valid, held by control until MOC seen
- rw  input  1  1 = read, 0 = write
- mode  input  2  00 byte, 01 halfword, 10 word, 11 treated as word
- sign_ext  input  1  loads only: 1 sign-extends byte/halfword, 0 zero-extends
- address  input  32  byte address (from MAR)
- data_in  input  32  write data (from MDR); byte uses [7:0], halfword uses [15:0]
- data_out  output  32  read data to MDR, valid while moc=1
- moc  output  1  memory operation complete
- addr_err  output  1  access rejected (misaligned or out of range), valid while moc=1

## Operation
- FSM states: IDLE, BUSY, DONE.
- IDLE: moc=0. On edge with mov=1: latch address, data_in, rw, mode, sign_ext; load wait counter with LATENCY-1; go BUSY. Inputs are ignored after latching.
- BUSY: each edge, if counter≠0 decrement; if counter=0 perform access, update data_out/addr_err, go DONE.
- DONE: moc=1; data_out and addr_err held. Stay while mov=1 (no repeat access). On edge with mov=0 go IDLE; moc falls after that edge.
- Byte order big-endian: word at A = {mem[A], mem[A+1], mem[A+2], mem[A+3]}; halfword at A = {mem[A], mem[A+1]}.
- Errors: halfword with address[0]=1, word with address[1:0]≠0, or any address bit ≥ ADDR_BITS set → addr_err=1, data_out=0, no memory write.
- Read: byte → {24 ext, byte}; halfword → {16 ext, half}; ext = sign bit if sign_ext else 0. Word ignores sign_ext.
- Write: only the addressed bytes change; data_out=0 on write completion.
- Memory array is not cleared by reset; contents undefined until written.

## Timing
- Reset values: moc=0, addr_err=0, data_out=0, state IDLE, counter 0.
- mov sampled high at edge N → moc high after edge N+LATENCY (LATENCY=2: BUSY after N, counter 1→0 at N+1, access at N+2).
- Memory write commits only on the final BUSY edge (N+LATENCY).
- Minimum MOV-to-next-MOV: LATENCY+1 edges plus one IDLE edge; mov low in DONE for one edge required before next request.
- Reset mid-BUSY: returns IDLE next edge, pending write aborted, memory unchanged, moc stays 0.
- Reset in DONE: moc, addr_err, data_out cleared on that edge.
- Reset has priority over mov on the same edge.
- mov dropping during BUSY: access still completes; DONE exits on the next edge since mov=0.

## Test plan
- Word write 0xDEADBEEF @0x10, then word read @0x10 → data_out=0xDEADBEEF, addr_err=0, moc rises exactly LATENCY edges after mov sampled.
- After above: byte read @0x10 sign_ext=1 → 0xFFFFFFDE; byte read @0x13 sign_ext=0 → 0x000000EF; halfword read @0x12 sign_ext=1 → 0xFFFFBEEF.
- Halfword write 0x1234 @0x12, byte write 0x55 @0x10, word read @0x10 → 0x55AD1234.
- Word write @0x11 → moc=1, addr_err=1, data_out=0; word read @0x10 afterwards still 0x55AD1234; address 0x200 word read → addr_err=1.
- Word write 0xCAFEF00D @0x20, assert reset one edge after mov accepted (mid-BUSY) → moc=0, all outputs 0; subsequent read @0x20 returns prior contents (e.g., 0 if preloaded 0).
- Hold mov=1 five edges past moc rise → moc stays 1, exactly one write performed; drop mov → moc low after next edge; new request then accepted normally.
